prime_scan_ctrl: RTL and testbench
==================================

// Module: prime_scan_ctrl
// PURPOSE
//  Sequences the 3-bit primality datapath over a candidate range [lo..hi].
//  Tests one candidate per cycle and streams results over a valid/ready port.
//  Keeps a running prime count.
//  Sits between a host/register stage (start, bounds) and a downstream consumer.
// PARAMETERS
//  CNT_W     4  width of prime_cnt; saturates at 2**CNT_W-1
//  EMIT_ALL  0  0: emit primes only; 1: emit every candidate with p_is_prime flag
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      begin scan; sampled only in IDLE or DONE
//  lo          in   3      first candidate, latched on accepted start
//  hi          in   3      last candidate, latched on accepted start
//  busy        out  1      high in SCAN or EMIT
//  done        out  1      high in DONE until next accepted start
//  p_valid     out  1      result beat valid
//  p_ready     in   1      consumer accepts beat
//  p_data      out  3      candidate value of the beat
//  p_is_prime  out  1      primality of p_data
//  prime_cnt   out  CNT_W  primes found in current/last scan
//  err         out  1      only with PRIME_SCAN_ERR_EN: range error
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, p_valid, p_data, p_is_prime, prime_cnt, err all 0.
//  - Prime set {2,3,5,7}; 0 and 1 are non-prime.
//  - FSM IDLE/DONE -start-> SCAN. On this edge: cur<=lo, hi_q<=hi, prime_cnt<=0, done<=0.
//  - start while busy is ignored. start in DONE restarts immediately.
//  - SCAN: evaluate cur in one cycle. If prime, prime_cnt+=1 (saturating).
//    - Emit when prime or EMIT_ALL=1: register p_data=cur and p_is_prime, go to EMIT.
//    - Otherwise: if cur==hi_q go to DONE, else cur<=cur+1 (mod 8), stay in SCAN.
//  - EMIT: p_valid=1. p_data and p_is_prime stay stable while p_ready=0.
//    - On p_valid&&p_ready: drop p_valid. If cur==hi_q go to DONE, else cur<=cur+1 and go to SCAN.
//  - Latency: start at edge N gives SCAN at N+1. First beat has p_valid at N+2 at earliest.
//  - Throughput: non-emitted candidate = 1 cycle; emitted candidate >= 2 cycles.
//  - lo==hi: exactly one candidate is tested.
//  - Counter wraps 7->0. The scan always terminates on cur==hi_q.
//  - rst mid-scan: returns to IDLE next edge and drops p_valid. A pending beat is lost.
// CONFIGURATION
//  - PRIME_SCAN_ERR_EN defined:
//    - start with lo>hi: go straight to DONE with err=1 and prime_cnt=0. No beats are emitted.
//    - err clears on the next accepted start.
//  - PRIME_SCAN_ERR_EN undefined:
//    - no err port. lo>hi scans with wrap-around: lo..7 then 0..hi.
// STRUCTURE
//  - prime_pkg:
//    - CAND_W=3
//    - state_t enum {IDLE,SCAN,EMIT,DONE}
//    - PRIME_MASK=8'b1010_1100 (bit i set if i is prime)
//  - Sub-module prime3_lut (combinational, in 3 -> out 1):
//    out = (a[0]&a[2]) | (~a[2]&a[1]). Instantiate once on cur.
//  - Top holds the FSM, cur/hi_q registers, count, output registers.
// TESTING
//  1. lo=0,hi=7,p_ready=1,EMIT_ALL=0 -> beats 2,3,5,7. Then done=1, prime_cnt=4.
//  2. lo=2,hi=5 -> beats 2,3,5, prime_cnt=3.
//     lo=hi=4 -> no beats, done=1, prime_cnt=0.
//  3. lo=6,hi=1:
//     - macro off: beat 7 only, prime_cnt=1.
//     - macro on: err=1, done=1, prime_cnt=0, no beats.
//  4. Backpressure: p_ready=0 for 3 cycles on beat 3 -> p_valid held, p_data=3 stable.
//     Scan resumes after handshake. start pulses while busy are ignored.
//  5. EMIT_ALL=1, lo=0,hi=3 -> beats (0,0)(1,0)(2,1)(3,1), prime_cnt=2.
//  6. rst asserted in EMIT -> next cycle IDLE, p_valid=0, prime_cnt=0.
//     A new start then behaves as in test 1.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared types and constants for the 3-bit prime scan controller.
package prime_pkg;

  localparam int CAND_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit i is set when i is prime.
  localparam logic [7:0] PRIME_MASK = 8'b1010_1100;

endpackage

// File: rtl/prime3_lut.sv
// Combinational primality test for a 3-bit candidate (primes 2, 3, 5, 7).
module prime3_lut
  import prime_pkg::*;
(
  input  logic [CAND_W-1:0] a_i,
  output logic              y_o
);

  assign y_o = (a_i[0] & a_i[2]) | (~a_i[2] & a_i[1]);

endmodule

// File: rtl/prime_scan_ctrl.sv
// Scans candidates lo..hi (wrapping mod 8), streams primes over valid/ready and
// counts them. Define PRIME_SCAN_ERR_EN to reject lo>hi with an err flag.
module prime_scan_ctrl
  import prime_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter bit EMIT_ALL = 1'b0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CAND_W-1:0] lo,
  input  logic [CAND_W-1:0] hi,
  output logic              busy,
  output logic              done,
  output logic              p_valid,
  input  logic              p_ready,
  output logic [CAND_W-1:0] p_data,
  output logic              p_is_prime,
`ifdef PRIME_SCAN_ERR_EN
  output logic              err,
`endif
  output logic [CNT_W-1:0]  prime_cnt
);

  state_t              state_q, state_d;
  logic [CAND_W-1:0]   cur_q, cur_d;
  logic [CAND_W-1:0]   hi_q, hi_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CAND_W-1:0]   p_data_q, p_data_d;
  logic                p_isp_q, p_isp_d;
  logic                err_q, err_d;
  logic                cur_is_prime;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  prime3_lut u_lut (
    .a_i (cur_q),
    .y_o (cur_is_prime)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    p_data_d = p_data_q;
    p_isp_d  = p_isp_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_d = '0;
          err_d = 1'b0;
          cur_d = lo;
          hi_d  = hi;
`ifdef PRIME_SCAN_ERR_EN
          if (lo > hi) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
`else
          state_d = SCAN;
`endif
        end
      end
      SCAN: begin
        if (cur_is_prime) cnt_d = sat_inc(cnt_q);
        if (cur_is_prime || EMIT_ALL) begin
          p_data_d = cur_q;
          p_isp_d  = cur_is_prime;
          state_d  = EMIT;
        end else if (cur_q == hi_q) begin
          state_d = DONE;
        end else begin
          cur_d = cur_q + CAND_W'(1);
        end
      end
      EMIT: begin
        // p_data/p_is_prime hold their registered values until the handshake.
        if (p_ready) begin
          if (cur_q == hi_q) begin
            state_d = DONE;
          end else begin
            cur_d   = cur_q + CAND_W'(1);
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      p_data_q <= '0;
      p_isp_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      p_data_q <= p_data_d;
      p_isp_q  <= p_isp_d;
      err_q    <= err_d;
    end
  end

  assign busy       = (state_q == SCAN) || (state_q == EMIT);
  assign done       = (state_q == DONE);
  assign p_valid    = (state_q == EMIT);
  assign p_data     = p_data_q;
  assign p_is_prime = p_isp_q;
  assign prime_cnt  = cnt_q;
`ifdef PRIME_SCAN_ERR_EN
  assign err        = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Bench for prime_scan_ctrl: two instances (primes-only, and emit-all with a narrow counter).
module tb_prime_scan_ctrl;

  logic clk = 1'b0;
  logic rst, start_r, sel, p_ready;
  logic [2:0] lo, hi;
  logic start0, start1;

  logic busy0, done0, pv0, pip0;
  logic [2:0] pd0;
  logic [3:0] cnt0;
  logic busy1, done1, pv1, pip1;
  logic [2:0] pd1;
  logic [1:0] cnt1;
`ifdef PRIME_SCAN_ERR_EN
  logic err0, err1, err;
`endif

  logic busy, done, pv, pip;
  logic [2:0] pd;
  logic [3:0] cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign start0 = start_r & ~sel;
  assign start1 = start_r & sel;
  assign busy   = sel ? busy1 : busy0;
  assign done   = sel ? done1 : done0;
  assign pv     = sel ? pv1   : pv0;
  assign pip    = sel ? pip1  : pip0;
  assign pd     = sel ? pd1   : pd0;
  assign cnt    = sel ? {2'b00, cnt1} : cnt0;
`ifdef PRIME_SCAN_ERR_EN
  assign err    = sel ? err1 : err0;
`endif

  prime_scan_ctrl #(.CNT_W(4), .EMIT_ALL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .lo(lo), .hi(hi),
    .busy(busy0), .done(done0), .p_valid(pv0), .p_ready(p_ready),
    .p_data(pd0), .p_is_prime(pip0),
`ifdef PRIME_SCAN_ERR_EN
    .err(err0),
`endif
    .prime_cnt(cnt0)
  );

  prime_scan_ctrl #(.CNT_W(2), .EMIT_ALL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .lo(lo), .hi(hi),
    .busy(busy1), .done(done1), .p_valid(pv1), .p_ready(p_ready),
    .p_data(pd1), .p_is_prime(pip1),
`ifdef PRIME_SCAN_ERR_EN
    .err(err1),
`endif
    .prime_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: always ready; 1: random ready plus ignored start pulses; 2: stall 3 cycles on beat 3
  task automatic run_scan(input logic [2:0] l, input logic [2:0] h, input int mode);
    logic [2:0] ed[$];
    logic       ep[$];
    logic [2:0] gd[$];
    logic       gp[$];
    logic [2:0] c, prev_d;
    int  n, maxc, hold;
    bit  isp, errc, prev_v, prev_r, rdy, first_emit;
    errc = 1'b0;
`ifdef PRIME_SCAN_ERR_EN
    errc = (l > h);
`endif
    n = 0;
    c = l;
    if (!errc) begin
      for (int k = 0; k < 8; k++) begin
        isp = (c == 3'd2) || (c == 3'd3) || (c == 3'd5) || (c == 3'd7);
        if (isp) n++;
        if (isp || sel) begin
          ed.push_back(c);
          ep.push_back(isp);
        end
        if (c == h) break;
        c = c + 3'd1;
      end
    end
    maxc = sel ? 3 : 15;
    if (n > maxc) n = maxc;
    first_emit = (ed.size() > 0) && (ed[0] == l);

    @(negedge clk);
    start_r = 1'b1; lo = l; hi = h; p_ready = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    chk("start_busy", 32'(busy), 32'(!errc));
    chk("start_done", 32'(done), 32'(errc));
    chk("start_cnt", 32'(cnt), 32'd0);
    chk("start_valid", 32'(pv), 32'd0);
`ifdef PRIME_SCAN_ERR_EN
    chk("start_err", 32'(err), 32'(errc));
`endif
    prev_v = 1'b0; prev_r = 1'b1; prev_d = '0; hold = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc == 1 && first_emit) chk("first_latency", 32'(pv), 32'd1);
      if (prev_v && !prev_r) begin
        chk("hold_valid", 32'(pv), 32'd1);
        chk("hold_data", 32'(pd), 32'(prev_d));
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else if (pv && pd == 3'd3 && hold < 3) begin rdy = 1'b0; hold++; end
      else rdy = 1'b1;
      p_ready = rdy;
      if (pv && rdy) begin
        gd.push_back(pd);
        gp.push_back(pip);
      end
      if (mode != 0 && busy && $urandom_range(0, 2) == 0) begin
        start_r = 1'b1; lo = 3'($urandom); hi = 3'($urandom);
      end
      prev_v = pv; prev_r = rdy; prev_d = pd;
      @(negedge clk);
      start_r = 1'b0;
    end
    chk("scan_timeout", 32'(done), 32'd1);
    chk("beat_count", 32'(gd.size()), 32'(ed.size()));
    for (int k = 0; k < ed.size(); k++) begin
      if (k < gd.size()) begin
        chk("beat_data", 32'(gd[k]), 32'(ed[k]));
        chk("beat_prime", 32'(gp[k]), 32'(ep[k]));
      end
    end
    chk("end_cnt", 32'(cnt), 32'(n));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_valid", 32'(pv), 32'd0);
`ifdef PRIME_SCAN_ERR_EN
    chk("end_err", 32'(err), 32'(errc));
`endif
    p_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_r = 1'b0; sel = 1'b0; p_ready = 1'b1; lo = '0; hi = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(pv), 32'd0);
    chk("rst_data", 32'(pd), 32'd0);
    chk("rst_prime", 32'(pip), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
`ifdef PRIME_SCAN_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;

    run_scan(3'd0, 3'd7, 0);
    run_scan(3'd2, 3'd5, 0);
    run_scan(3'd4, 3'd4, 0);
    run_scan(3'd6, 3'd1, 0);
    run_scan(3'd0, 3'd7, 2);

    sel = 1'b1;
    run_scan(3'd0, 3'd3, 0);
    run_scan(3'd0, 3'd7, 1);
    sel = 1'b0;

    // Reset while a beat is pending.
    @(negedge clk);
    start_r = 1'b1; lo = 3'd0; hi = 3'd7; p_ready = 1'b0;
    @(negedge clk);
    start_r = 1'b0;
    for (int cyc = 0; cyc < 20 && !pv; cyc++) @(negedge clk);
    chk("rst_reach_emit", 32'(pv), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; p_ready = 1'b1;
    chk("midrst_valid", 32'(pv), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    run_scan(3'd0, 3'd7, 0);

    for (int i = 0; i < 10; i++) begin
      sel = 1'($urandom_range(0, 1));
      run_scan(3'($urandom), 3'($urandom), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
